// File: rtl/instr_fetch_pkg.sv
// Shared constants, the response-disposition type and the request credit rule
// for the instruction fetch stage.
package instr_fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_DROP,
    RESP_PUSH
  } resp_action_e;

  // A request may only go out if every answer already in flight, plus this one,
  // is guaranteed a buffer slot.
  function automatic logic credit_ok(input int outstanding, input int buf_count,
                                     input int buf_depth, input int max_outstand);
    return ((outstanding + buf_count) < buf_depth) && (outstanding < max_outstand);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Memory request/response, decode hand-off and redirect signals of the fetch stage.
interface instr_fetch_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   memReqValid;
  logic                   memReqReady;
  logic [ADDR_WIDTH-1:0]  memReqAddr;
  logic                   memRespValid;
  logic [INSTR_WIDTH-1:0] memRespData;
  logic                   instrValid;
  logic                   instrReady;
  logic [INSTR_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0]  pcReadData;
  logic                   pcWriteEnable;
  logic [ADDR_WIDTH-1:0]  pcWriteData;

  modport master (
    output memReqValid, memReqAddr, instrValid, instr, pcReadData,
    input  memReqReady, memRespValid, memRespData, instrReady, pcWriteEnable, pcWriteData
  );

  modport slave (
    input  memReqValid, memReqAddr, instrValid, instr, pcReadData,
    output memReqReady, memRespValid, memRespData, instrReady, pcWriteEnable, pcWriteData
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Synchronous FIFO holding fetched {instr, pc} entries; flush wins over push/pop.
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) push |-> (int'(count) != DEPTH));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, issues in-order word reads under a credit rule,
// tags returning words with their PC, and kills responses made stale by a redirect.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    INSTR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
  parameter int                    BUF_DEPTH    = 2,
  parameter int                    MAX_OUTSTAND = 2
) (
  input logic         clk,
  input logic         reset,
  instr_fetch_if.master bus
);
  localparam int OW = $clog2(MAX_OUTSTAND+1);
  localparam int CW = $clog2(BUF_DEPTH+1);

  logic [ADDR_WIDTH-1:0]             fetch_pc;
  logic [ADDR_WIDTH-1:0]             resp_pc;
  logic [ADDR_WIDTH-1:0]             redirect_pc;
  logic [OW-1:0]                     outstanding;
  logic [OW-1:0]                     outstanding_nxt;
  logic [OW-1:0]                     kill_cnt;
  logic [CW-1:0]                     buf_count;
  logic [INSTR_WIDTH+ADDR_WIDTH-1:0] head;
  logic                              req_fire;
  logic                              push;
  logic                              pop;
  resp_action_e                      resp_action;

  assign redirect_pc = {bus.pcWriteData[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    bus.memReqValid = !reset && !bus.pcWriteEnable &&
                      credit_ok(int'(outstanding), int'(buf_count), BUF_DEPTH, MAX_OUTSTAND);
    bus.memReqAddr  = {fetch_pc[ADDR_WIDTH-1:2], 2'b00};
  end

  assign req_fire = bus.memReqValid && bus.memReqReady;

  // A response landing in a redirect cycle belongs to the old stream, so it is dropped too.
  always_comb begin
    resp_action = RESP_NONE;
    if (bus.memRespValid) begin
      if (kill_cnt != '0 || bus.pcWriteEnable) resp_action = RESP_DROP;
      else                                     resp_action = RESP_PUSH;
    end
  end

  assign push            = (resp_action == RESP_PUSH);
  assign pop             = bus.instrValid && bus.instrReady && !bus.pcWriteEnable;
  assign outstanding_nxt = outstanding + OW'(req_fire) - OW'(bus.memRespValid);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      kill_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (bus.pcWriteEnable) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        kill_cnt <= outstanding_nxt;
      end else begin
        if (req_fire)                  fetch_pc <= fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
        if (push)                      resp_pc  <= resp_pc + ADDR_WIDTH'(INSTR_BYTES);
        if (resp_action == RESP_DROP)  kill_cnt <= kill_cnt - OW'(1);
      end
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (INSTR_WIDTH + ADDR_WIDTH)
  ) u_buf (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.pcWriteEnable),
    .din   ({bus.memRespData, resp_pc}),
    .head  (head),
    .count (buf_count)
  );

  always_comb begin
    bus.instrValid = (buf_count != '0);
    {bus.instr, bus.pcReadData} = bus.instrValid ? head : '0;
  end

  a_resp_expected: assert property (@(posedge clk) disable iff (reset)
                                    bus.memRespValid |-> (outstanding != '0));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized bench for instr_fetch with an in-order memory model and
// an expected-PC-stream reference model.
module tb_instr_fetch;
  localparam int AW = 32;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

  instr_fetch #(
    .ADDR_WIDTH   (AW),
    .INSTR_WIDTH  (IW),
    .RESET_PC     ('0),
    .BUF_DEPTH    (2),
    .MAX_OUTSTAND (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mem_q[$];
  logic [31:0] req_pc = '0;
  logic [31:0] exp_pc = '0;
  bit          flushed_prev = 1'b0;
  bit          hold_instr_prev = 1'b0;
  bit          hold_req_prev = 1'b0;
  logic [31:0] prev_instr, prev_pc, prev_addr;
  int          delivered = 0;
  logic [31:0] last_pc = '0;
  logic [31:0] a0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit rst_i, input bit req_rdy, input bit dec_rdy,
                       input bit redir, input logic [31:0] tgt, input bit resp_en);
    bit resp;
    bit req_fire;
    reset             = rst_i;
    resp              = !rst_i && resp_en && (mem_q.size() > 0);
    bus.memRespValid  = resp;
    bus.memRespData   = resp ? mem_word(mem_q[0]) : '0;
    bus.memReqReady   = req_rdy;
    bus.instrReady    = dec_rdy;
    bus.pcWriteEnable = redir;
    bus.pcWriteData   = tgt;
    @(negedge clk);
    if (!rst_i) begin
      if (flushed_prev) chk("valid_after_flush", 32'(bus.instrValid), 32'd0);
      if (hold_instr_prev) begin
        chk("valid_hold", 32'(bus.instrValid), 32'd1);
        chk("instr_hold", bus.instr, prev_instr);
        chk("pc_hold", bus.pcReadData, prev_pc);
      end
      if (hold_req_prev && !redir) begin
        chk("req_valid_hold", 32'(bus.memReqValid), 32'd1);
        chk("req_addr_hold", bus.memReqAddr, prev_addr);
      end
      if (redir) chk("no_req_on_redirect", 32'(bus.memReqValid), 32'd0);
      if (bus.memReqValid) chk("req_addr", bus.memReqAddr, req_pc);
      if (bus.instrValid && dec_rdy && !redir) begin
        chk("deliver_pc", bus.pcReadData, exp_pc);
        chk("deliver_instr", bus.instr, mem_word(exp_pc));
        last_pc = bus.pcReadData;
        exp_pc  = exp_pc + 32'd4;
        delivered++;
      end
    end
    req_fire        = !rst_i && bus.memReqValid && req_rdy;
    hold_instr_prev = !rst_i && !redir && bus.instrValid && !dec_rdy;
    prev_instr      = bus.instr;
    prev_pc         = bus.pcReadData;
    hold_req_prev   = !rst_i && !redir && bus.memReqValid && !req_rdy;
    prev_addr       = bus.memReqAddr;
    flushed_prev    = rst_i || redir;
    @(posedge clk);
    #1;
    if (rst_i) begin
      mem_q.delete();
      req_pc = '0;
      exp_pc = '0;
    end else begin
      if (resp) void'(mem_q.pop_front());
      if (req_fire) begin
        mem_q.push_back(req_pc);
        req_pc = req_pc + 32'd4;
      end
      if (redir) begin
        req_pc = tgt & ~32'd3;
        exp_pc = tgt & ~32'd3;
      end
    end
  endtask

  task automatic do_reset();
    repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    repeat (4) cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.memReqReady = 1'b0; bus.memRespValid = 1'b0; bus.memRespData = '0;
    bus.instrReady = 1'b0; bus.pcWriteEnable = 1'b0; bus.pcWriteData = '0;

    // Reset state
    do_reset();
    chk("rst_instr_valid", 32'(bus.instrValid), 32'd0);
    chk("rst_req_valid", 32'(bus.memReqValid), 32'd0);
    chk("rst_req_addr", bus.memReqAddr, 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_pc", bus.pcReadData, 32'd0);

    // 1: free-running stream
    delivered = 0;
    repeat (30) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    chk("t1_rate", 32'(delivered >= 18), 32'd1);

    // 2: decode stalled then released
    do_reset();
    repeat (10) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("t2_valid", 32'(bus.instrValid), 32'd1);
    chk("t2_head_pc", bus.pcReadData, 32'd0);
    chk("t2_req_stall", 32'(bus.memReqValid), 32'd0);
    delivered = 0;
    repeat (6) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    chk("t2_released", 32'(delivered >= 3), 32'd1);

    // 3: memory not ready
    drain();
    a0 = req_pc;
    repeat (5) cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    chk("t3_req_valid", 32'(bus.memReqValid), 32'd1);
    chk("t3_no_advance", bus.memReqAddr, a0);

    // 4: two outstanding, then redirect
    drain();
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("t4_outstanding", 32'(mem_q.size()), 32'd2);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
    delivered = 0;
    for (int i = 0; i < 20 && delivered == 0; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    chk("t4_delivered", 32'(delivered), 32'd1);
    chk("t4_first_pc", last_pc, 32'h100);

    // 5: back-to-back redirects
    drain();
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 1'b1);
    delivered = 0;
    for (int i = 0; i < 20 && delivered == 0; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    chk("t5_delivered", 32'(delivered), 32'd1);
    chk("t5_first_pc", last_pc, 32'h300);

    // 6: unaligned redirect, then reset mid-stream
    drain();
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h203, 1'b1);
    chk("t6_align", bus.memReqAddr, 32'h200);
    repeat (6) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    chk("t6_rst_valid", 32'(bus.instrValid), 32'd0);
    chk("t6_rst_addr", bus.memReqAddr, 32'd0);
    repeat (4) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);

    // Address wrap
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    delivered = 0;
    for (int i = 0; i < 30 && delivered < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    chk("wrap_count", 32'(delivered), 32'd4);
    chk("wrap_pc", last_pc, 32'd4);

    // Randomized traffic
    delivered = 0;
    for (int i = 0; i < 600; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 24) == 0), $urandom, 1'($urandom_range(0, 4) != 0));
    end
    chk("rand_progress", 32'(delivered > 50), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
